num_split_seq: RTL and testbench

- Parametrised, sequential binary-to-BCD digit splitter. Successor to the combinational divide-by-10 chain.
- Converts a W-bit signed or unsigned value into DIGITS BCD digits using a shift-add-3 (double-dabble) engine, one bit per clock, with a start/busy/done handshake.
- Sits between the calculator datapath and the 7-segment display driver. Adds sign magnitude, overflow saturation and optional leading-zero blanking.

---
 rtl/num_split_seq.sv | 124 ++++++++++++
 tb/tb_num_split_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/num_split_seq.sv
// Sequential binary-to-BCD splitter (double-dabble, one bit per clock) with sign
// magnitude, overflow saturation. Define NUM_SPLIT_SEQ_LZB_EN to blank leading zeros.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last published result
// SHIFT | W add-3/shift steps on {acc, mag}
// FIN   | publish bcd/neg/ovf, pulse done
module num_split_seq #(
    parameter int W      = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          v,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t        state;
    logic [BW-1:0] acc;
    logic [BW-1:0] acc_adj;
    logic [BW-1:0] pub_sat;
    logic [BW-1:0] pub_bcd;
    logic [W-1:0]  mag;
    logic [W-1:0]  v_mag;
    logic [CW-1:0] count;
    logic          sign;
    logic          ovf_acc;
    logic          v_neg;

    // Two's-complement negate wraps -2^(W-1) onto 2^(W-1), which fits unsigned W bits.
    assign v_neg = (SIGNED != 0) && v[W-1];
    assign v_mag = v_neg ? ((~v) + W'(1)) : v;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign pub_sat = ovf_acc ? {DIGITS{4'h9}} : acc;

`ifdef NUM_SPLIT_SEQ_LZB_EN
    logic seen;

    always_comb begin
        pub_bcd = pub_sat;
        seen    = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (pub_sat[4*i +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                pub_bcd[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    assign pub_bcd = pub_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            acc     <= '0;
            mag     <= '0;
            count   <= '0;
            sign    <= 1'b0;
            ovf_acc <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag     <= v_mag;
                        sign    <= v_neg;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        count   <= CW'(W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bit leaving the top digit means the value no longer fits DIGITS digits.
                    {acc, mag} <= {acc_adj[BW-2:0], mag, 1'b0};
                    ovf_acc    <= ovf_acc | acc_adj[BW-1];
                    count      <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    bcd   <= pub_bcd;
                    neg   <= sign;
                    ovf   <= ovf_acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_num_split_seq.sv
// Scoreboard bench for num_split_seq: default, unsigned and 3-digit instances,
// reference values from integer division; honours NUM_SPLIT_SEQ_LZB_EN.
module tb_num_split_seq;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start0, start1, start2;
    logic [15:0] v0, v1, v2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        neg0, neg1, neg2;
    logic        ovf0, ovf1, ovf2;
    logic [19:0] bcd0, bcd1;
    logic [11:0] bcd2;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int n_chk  = 0;
    int n_fail = 0;

    num_split_seq #(.W(16), .DIGITS(5), .SIGNED(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .v(v0), .busy(busy0),
        .done(done0), .bcd(bcd0), .neg(neg0), .ovf(ovf0));

    num_split_seq #(.W(16), .DIGITS(5), .SIGNED(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .v(v1), .busy(busy1),
        .done(done1), .bcd(bcd1), .neg(neg1), .ovf(ovf1));

    num_split_seq #(.W(16), .DIGITS(3), .SIGNED(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .v(v2), .busy(busy2),
        .done(done2), .bcd(bcd2), .neg(neg2), .ovf(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int digits, input bit signd, input logic [15:0] val);
        exp_t   e;
        longint m;
        longint lim;
        e   = '0;
        m   = longint'(val);
        lim = 1;
        if (signd && val[15]) begin
            e.neg = 1'b1;
            m     = 65536 - m;
        end
        repeat (digits) lim = lim * 10;
        lim = lim - 1;
        if (m > lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < digits; i++) begin
                e.bcd[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
`ifdef NUM_SPLIT_SEQ_LZB_EN
            for (int i = digits - 1; i >= 1; i--) begin
                if (e.bcd[4*i +: 4] != 4'h0) break;
                e.bcd[4*i +: 4] = 4'hF;
            end
`endif
        end
        return e;
    endfunction

    function automatic logic busy_of(input int u);
        case (u)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic done_of(input int u);
        case (u)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic set_in(input int u, input logic s, input logic [15:0] val);
        case (u)
            0:       begin start0 = s; v0 = val; end
            1:       begin start1 = s; v1 = val; end
            default: begin start2 = s; v2 = val; end
        endcase
    endtask

    task automatic take(input int u, input logic [39:0] gb, input logic gn, input logic go);
        exp_t e;
        bit   empty;
        empty = 1'b0;
        case (u)
            0:       if (sb0.size() == 0) empty = 1'b1; else e = sb0.pop_front();
            1:       if (sb1.size() == 0) empty = 1'b1; else e = sb1.pop_front();
            default: if (sb2.size() == 0) empty = 1'b1; else e = sb2.pop_front();
        endcase
        if (empty) begin
            chk($sformatf("u%0d unexpected done", u), 64'd1, 64'd0);
        end else begin
            chk($sformatf("u%0d bcd", u), 64'(gb), 64'(e.bcd));
            chk($sformatf("u%0d neg", u), 64'(gn), 64'(e.neg));
            chk($sformatf("u%0d ovf", u), 64'(go), 64'(e.ovf));
        end
    endtask

    always @(negedge clk) if (done0) take(0, 40'(bcd0), neg0, ovf0);
    always @(negedge clk) if (done1) take(1, 40'(bcd1), neg1, ovf1);
    always @(negedge clk) if (done2) take(2, 40'(bcd2), neg2, ovf2);

    // One conversion with latency/busy checks; poke re-issues start with new v while busy.
    task automatic run(input int u, input logic [15:0] val, input bit poke);
        int   n;
        bit   busy_ok;
        exp_t e;
        @(negedge clk);
        set_in(u, 1'b1, val);
        e = model((u == 2) ? 3 : 5, (u != 1), val);
        case (u)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
        @(posedge clk);
        #1;
        set_in(u, 1'b0, val);
        busy_ok = busy_of(u);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done_of(u)) break;
            if (!busy_of(u)) busy_ok = 1'b0;
            if (poke) set_in(u, (n == 3 || n == 9), 16'($urandom));
        end
        set_in(u, 1'b0, val);
        chk($sformatf("u%0d latency %0h", u, val), 64'(n), 64'd17);
        chk($sformatf("u%0d busy during", u), 64'(busy_ok), 64'd1);
        chk($sformatf("u%0d busy at done", u), 64'(busy_of(u)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        set_in(0, 1'b0, 16'd0);
        set_in(1, 1'b0, 16'd0);
        set_in(2, 1'b0, 16'd0);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset bcd", 64'(bcd0), 64'd0);
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset neg", 64'(neg0), 64'd0);
        chk("reset ovf", 64'(ovf0), 64'd0);
        rst_n = 1'b1;

        run(0, 16'd1234, 1'b0);
        run(0, 16'hFFFF, 1'b0);
        run(0, 16'h8000, 1'b0);
        run(0, 16'd0,    1'b0);
        run(0, 16'd42,   1'b0);
        run(0, 16'hFECF, 1'b0);
        run(0, 16'h7FFF, 1'b0);
        run(0, 16'd100,  1'b0);
        for (int i = 0; i < 4; i++) run(0, 16'($urandom), 1'b0);
        run(0, 16'd1234, 1'b1);
        repeat (25) @(negedge clk);
        chk("u0 scoreboard drained", 64'(sb0.size()), 64'd0);

        run(1, 16'hFFFF, 1'b0);
        run(1, 16'h8000, 1'b0);
        run(1, 16'd42,   1'b0);
        run(2, 16'd1000, 1'b0);
        run(2, 16'd999,  1'b0);
        run(2, 16'd7,    1'b0);
        run(2, 16'hFFFF, 1'b0);
        run(2, 16'hFC18, 1'b0);
        run(0, 16'hFB2E, 1'b0);

        // Reset in cycle 8 of a conversion: outputs clear at once, no done follows.
        @(negedge clk);
        set_in(0, 1'b1, 16'd4321);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 16'd4321);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst bcd", 64'(bcd0), 64'd0);
        chk("midrst neg", 64'(neg0), 64'd0);
        chk("midrst busy", 64'(busy0), 64'd0);
        chk("midrst done", 64'(done0), 64'd0);
        chk("midrst ovf", 64'(ovf0), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst no done", 64'(done0), 64'd0);
        run(0, 16'd4321, 1'b0);
        repeat (3) @(negedge clk);
        chk("final scoreboard", 64'(sb0.size() + sb1.size() + sb2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
